// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle core: data/instruction/address widths,
// instruction field positions and the fetch-stage state encoding.
// No ports (package).
package cpu_pkg;

    localparam int INST_W = 20;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    // Instruction field positions
    localparam int OPCODE_MSB = 19;
    localparam int OPCODE_LSB = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 12;
    localparam int RS1_MSB    = 11;
    localparam int RS1_LSB    = 8;
    localparam int RS2_MSB    = 7;
    localparam int RS2_LSB    = 4;
    localparam int FUNCT_MSB  = 3;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    // Fetch request tracking: IDLE = nothing outstanding, WAIT = one live request
    // outstanding, DRAIN = one outstanding request whose response must be discarded.
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect from
// execute and the instruction handshake towards decode.
//   master : the fetch unit (drives imem_req/imem_addr and inst_valid/inst_data/inst_pc)
//   slave  : memory + execute + decode side
interface fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INST_W = cpu_pkg::INST_W
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of DEPTH entries holding {pc, instruction} pairs.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din at the tail
//   pop      : drop the head
//   flush    : synchronous clear of all entries (head register keeps its value)
//   count    : number of valid entries
//   head     : registered copy of the oldest entry
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;

    // The head register is loaded with whatever will be the oldest entry after
    // this cycle; when that entry is being written right now it comes from din.
    always_comb begin
        rd_next = rd_ptr + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        head_d  = head_q;
        if (count_d != '0) begin
            head_d = (push && (wr_ptr == rd_next)) ? din : mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr  <= rd_next;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, keeps at most one instruction-memory
// request in flight, buffers responses in a prefetch FIFO and hands them to
// decode over a valid/ready handshake. A redirect flushes the FIFO, drops any
// in-flight response and restarts fetch at redirect_pc.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (master) : imem_req/imem_addr/imem_rvalid/imem_rdata,
//                  redirect_valid/redirect_pc,
//                  inst_valid/inst_ready/inst_data/inst_pc
//   perf_fetched, perf_flushed : only with FETCH_PERF_CNT_EN defined;
//                  accepted responses, and instructions discarded by redirects
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | one request outstanding, its response will be kept
// DRAIN | one request outstanding, its response will be discarded
module fetch_unit #(
    parameter int              ADDR_W   = cpu_pkg::ADDR_W,
    parameter int              INST_W   = cpu_pkg::INST_W,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_flushed
`endif
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              outstanding;
    logic              drop_pending;
    logic              pop;
    logic              acc;
    logic              req;
    logic [CW-1:0]     count;
    logic [CW:0]       occ_next;
    logic [ADDR_W+INST_W-1:0] head;
    logic [ADDR_W-1:0] resp_pc;

    assign outstanding  = (state_q != FETCH_IDLE);
    assign drop_pending = (state_q == FETCH_DRAIN);

    // Redirect flushes the FIFO, so a pop in that cycle is meaningless.
    assign pop = (count != '0) & bus.inst_ready & !bus.redirect_valid;

    // Responses while nothing is outstanding (e.g. left over from before a
    // reset) are ignored.
    assign acc = bus.imem_rvalid & outstanding & !drop_pending & !bus.redirect_valid;

    // Issue only if the FIFO will have a free slot after this cycle; that slot
    // is then reserved for the response, so a response can never overflow.
    assign occ_next = {1'b0, count} + (CW+1)'(acc) - (CW+1)'(pop);
    assign req = !rst & !bus.redirect_valid & (!outstanding | bus.imem_rvalid)
                 & (occ_next < (CW+1)'(DEPTH));

    // pc_q advanced when the request was issued and no redirect can have
    // happened since (that would have sent us to DRAIN), so the accepted
    // response belongs to pc_q - 1.
    assign resp_pc = pc_q - ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
            if (outstanding && !bus.imem_rvalid) begin
                state_d = FETCH_DRAIN;
            end else begin
                state_d = FETCH_IDLE;
            end
        end else if (req) begin
            state_d = FETCH_WAIT;
            pc_d    = pc_q + ADDR_W'(1);
        end else if (bus.imem_rvalid) begin
            state_d = FETCH_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (acc),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   ({resp_pc, bus.imem_rdata}),
        .count (count),
        .head  (head)
    );

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_pc    = head[ADDR_W+INST_W-1:INST_W];
    assign bus.inst_data  = head[INST_W-1:0];

`ifdef FETCH_PERF_CNT_EN
    // A redirect in WAIT throws away the live in-flight response as well; in
    // DRAIN that response was already counted by the earlier redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (acc) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (bus.redirect_valid) begin
                perf_flushed <= perf_flushed + 32'(count) + 32'(state_q == FETCH_WAIT);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Two instances share all control inputs:
// u_dut (RESET_PC=0) and u_wrap (RESET_PC=0xFFFE). The memory returns
// {4'hA, addr}. A queue-based model tracks what the prefetch buffer should hold.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, perf_fetched2, perf_flushed2;
`endif

    fetch_unit #(.DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched (perf_fetched)
        , .perf_flushed (perf_flushed)
`endif
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched (perf_fetched2)
        , .perf_flushed (perf_flushed2)
`endif
    );

    int checks = 0;
    int errors = 0;

    // model state
    logic [15:0] q[$];
    logic [15:0] pops2[$];
    bit          pend, live;
    logic [15:0] pend_addr;
    int          due;
    int          lat;
    logic [15:0] mpc, off;
    int unsigned m_fetched, m_flushed;

    bit          redir_r;
    logic [15:0] rpc_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.imem_rvalid = 1'b0;  bus2.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;     bus2.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus2.redirect_valid = 1'b0;
        bus.redirect_pc = '0;    bus2.redirect_pc = '0;
        bus.inst_ready = 1'b0;   bus2.inst_ready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("rst_imem_req", bus.imem_req, 0);
            chk("rst_inst_valid", bus.inst_valid, 0);
            chk("rst_inst_pc", bus.inst_pc, 0);
            chk("rst_inst_data", bus.inst_data, 0);
            chk("rst_wrap_imem_req", bus2.imem_req, 0);
            chk("rst_wrap_inst_valid", bus2.inst_valid, 0);
        end
        rst = 1'b0;
        q.delete();
        pops2.delete();
        pend = 1'b0; live = 1'b0; due = 0;
        mpc = 16'h0000; off = 16'hFFFE;
        m_fetched = 0; m_flushed = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic cycle(input bit redir, input logic [15:0] rpc, input bit rdy, input bit stray);
        bit rv, acc, pop, exp_req;
        int occ;
        logic [15:0] a2, h2;
        rv = pend && (due == 0);
        a2 = pend_addr + off;
        bus.imem_rvalid  = rv | stray;
        bus2.imem_rvalid = rv | stray;
        bus.imem_rdata   = rv ? {4'hA, pend_addr} : 20'($urandom);
        bus2.imem_rdata  = rv ? {4'hA, a2} : 20'($urandom);
        bus.redirect_valid = redir; bus2.redirect_valid = redir;
        bus.redirect_pc = rpc;      bus2.redirect_pc = rpc;
        bus.inst_ready = rdy;       bus2.inst_ready = rdy;
        #1;
        acc = rv && live && !redir;
        pop = (q.size() != 0) && rdy && !redir;
        occ = q.size() + int'(acc) - int'(pop);
        exp_req = !redir && (!pend || rv) && (occ < DEPTH);

        chk("imem_req", bus.imem_req, exp_req);
        chk("wrap_imem_req", bus2.imem_req, exp_req);
        if (exp_req) begin
            chk("imem_addr", bus.imem_addr, mpc);
            chk("wrap_imem_addr", bus2.imem_addr, 16'(mpc + off));
        end
        chk("inst_valid", bus.inst_valid, q.size() != 0);
        chk("wrap_inst_valid", bus2.inst_valid, q.size() != 0);
        if (q.size() != 0) begin
            h2 = q[0] + off;
            chk("inst_pc", bus.inst_pc, q[0]);
            chk("inst_data", bus.inst_data, {4'hA, q[0]});
            chk("wrap_inst_pc", bus2.inst_pc, h2);
            chk("wrap_inst_data", bus2.inst_data, {4'hA, h2});
            if (pop) pops2.push_back(bus2.inst_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushed", perf_flushed, m_flushed);
        chk("wrap_perf_fetched", perf_fetched2, m_fetched);
        chk("wrap_perf_flushed", perf_flushed2, m_flushed);
`endif
        // model update
        if (acc) m_fetched++;
        if (redir) m_flushed += q.size() + ((pend && live) ? 1 : 0);
        if (redir) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(pend_addr);
        end
        if (rv) pend = 1'b0;
        else if (pend) due--;
        if (redir) live = 1'b0;
        if (exp_req) begin
            pend = 1'b1; live = 1'b1; pend_addr = mpc; due = lat - 1;
        end
        if (redir) begin
            mpc = rpc; off = 16'h0000;
        end else if (exp_req) begin
            mpc = mpc + 16'h1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        drive_idle();
        lat = 1;

        // 1. reset, then first request to 0x0000 (wrap instance 0xFFFE)
        do_reset(2);

        // 2 + 6. streaming at L=1 with decode always ready
        for (int i = 0; i < 10; i++) begin
            cycle(0, 16'h0, 1, 0);
`ifdef FETCH_PERF_CNT_EN
            if (i == 3) begin
                chk("wrap_perf_fetched_3", perf_fetched2, 3);
                chk("wrap_perf_flushed_0", perf_flushed2, 0);
            end
`endif
        end
        chk("wrap_pop_count", pops2.size() >= 3, 1);
        if (pops2.size() >= 3) begin
            chk("wrap_pop0", pops2[0], 16'hFFFE);
            chk("wrap_pop1", pops2[1], 16'hFFFF);
            chk("wrap_pop2", pops2[2], 16'h0000);
        end

        // 3. backpressure
        do_reset(2);
        for (int i = 0; i < 6; i++) cycle(0, 16'h0, 0, 0);
        chk("bp_req_low", bus.imem_req, 0);
        for (int i = 0; i < 8; i++) cycle(0, 16'h0, 1, 0);

        // 4. redirect while request to 0x0005 is outstanding, L=3
        do_reset(1);
        lat = 3;
        for (int i = 0; i < 60 && !(pend && pend_addr == 16'h0005 && due > 0); i++)
            cycle(0, 16'h0, 1, 0);
        chk("reach_req_0005", pend && pend_addr == 16'h0005, 1);
        cycle(1, 16'h0040, 1, 0);
        for (int i = 0; i < 12; i++) cycle(0, 16'h0, 1, 0);

        // 5. redirect in the same cycle as a response, L=2
        lat = 2;
        for (int i = 0; i < 20 && !(pend && due == 0); i++) cycle(0, 16'h0, 1, 0);
        chk("reach_rvalid", pend && due == 0, 1);
        cycle(1, 16'h0100, 1, 0);
        bus.redirect_valid = 1'b0; bus2.redirect_valid = 1'b0;
        bus.imem_rvalid = 1'b0;    bus2.imem_rvalid = 1'b0;
        bus.inst_ready = 1'b1;     bus2.inst_ready = 1'b1;
        #1;
        chk("redir_req_next", bus.imem_req, 1);
        chk("redir_addr_next", bus.imem_addr, 16'h0100);
        for (int i = 0; i < 8; i++) cycle(0, 16'h0, 1, 0);

        // randomized traffic with redirects, backpressure, latency and mid-run resets
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            lat = $urandom_range(1, 4);
            if (i % 200 == 199) begin
                do_reset(1);
                cycle(0, 16'h0, 1, 1);
            end else begin
                redir_r = ($urandom_range(0, 19) == 0);
                rpc_r = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 3))
                                                     : 16'($urandom);
                cycle(redir_r, rpc_r, $urandom_range(0, 9) < 7, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
